aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 130 +++++++++++++
 tb/tb_aes_iter_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/256 encryptor, one round per clock, round keys expanded on the fly
module aes_iter_core #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       din,
    input  logic [KEY_LEN-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       dout,
    output logic               busy
);
    localparam int NR = (KEY_LEN == 256) ? 14 : 10;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t r_fsm;
    logic [127:0] r_state, r_dout, w_sr, w_mc, w_next, w_rk, w_round;
    logic [KEY_LEN-1:0] r_key, w_key_nx;
    logic [3:0] r_cnt;
    logic [7:0] r_rcon;
    logic [31:0] w_last, w_temp, w_acc;
    logic w_rot, w_final;

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    always_comb begin
        w_sr = '0;
        w_mc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127 - 8*(4*c + r) -: 8] = sb(r_state[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        for (int c = 0; c < 4; c++)
            w_mc[127 - 32*c -: 32] = mix(w_sr[127 - 32*c -: 32]);
    end

    // AES-256 alternates RotWord+Rcon (odd rounds) with SubWord-only steps
    assign w_last  = r_key[31:0];
    assign w_rot   = (KEY_LEN == 128) || r_cnt[0];
    assign w_temp  = w_rot ? sub_word({w_last[23:0], w_last[31:24]}) ^ {r_rcon, 24'h0} : sub_word(w_last);
    assign w_final = (r_cnt == 4'(NR));
    assign w_round = (w_final ? w_sr : w_mc) ^ w_rk;

    always_comb begin
        w_acc  = w_temp;
        w_next = '0;
        for (int i = 0; i < 4; i++) begin
            w_acc = w_acc ^ r_key[KEY_LEN-1-32*i -: 32];
            w_next[127 - 32*i -: 32] = w_acc;
        end
    end

    // 256-bit key register holds {previous round key, current round key}
    if (KEY_LEN == 128) begin : g_k128
        assign w_rk     = w_next;
        assign w_key_nx = w_next;
    end else begin : g_k256
        assign w_rk     = r_key[127:0];
        assign w_key_nx = {r_key[127:0], w_next};
    end

    assign in_ready  = rst_n && (r_fsm == IDLE);
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm == ROUND);
    assign dout      = r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_rcon  <= 8'h01;
            r_dout  <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid) begin
                    r_state <= din ^ key[KEY_LEN-1 -: 128];
                    r_key   <= key;
                    r_cnt   <= 4'd1;
                    r_rcon  <= 8'h01;
                    r_fsm   <= ROUND;
                end
                ROUND: begin
                    r_state <= w_round;
                    r_key   <= w_key_nx;
                    r_cnt   <= r_cnt + 4'd1;
                    if (w_rot) r_rcon <= xt(r_rcon);
                    if (w_final) begin
                        r_dout <= w_round;
                        r_cnt  <= '0;
                        r_fsm  <= DONE;
                    end
                end
                DONE: if (out_ready) r_fsm <= IDLE;
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: AES-128 and AES-256 instances checked against a table-driven FIPS-197 model
module tb_aes_iter_core;
    logic clk, rst_n;
    logic [1:0] v_in, v_or, o_ir, o_ov, o_busy;
    logic [1:0][127:0] v_din, o_dout;
    logic [1:0][255:0] v_key;
    logic [7:0] sbox_t [256];
    int errors = 0, checks = 0, nblk = 0, ndone = 0;

    localparam logic [127:0] D    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] V128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_iter_core #(.KEY_LEN(128)) u128 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in[0]), .in_ready(o_ir[0]), .din(v_din[0]),
        .key(v_key[0][255:128]), .out_valid(o_ov[0]), .out_ready(v_or[0]), .dout(o_dout[0]), .busy(o_busy[0])
    );
    aes_iter_core #(.KEY_LEN(256)) u256 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in[1]), .in_ready(o_ir[1]), .din(v_din[1]),
        .key(v_key[1]), .out_valid(o_ov[1]), .out_ready(v_or[1]), .dout(o_dout[1]), .busy(o_busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Textbook cipher: full key schedule table, byte-array state, circulant MixColumns
    function automatic logic [127:0] ref_enc(input int s, input logic [127:0] d, input logic [255:0] k);
        logic [31:0] w [60];
        logic [7:0] st [16];
        logic [7:0] t [16];
        logic [7:0] rc;
        logic [31:0] tmp;
        logic [127:0] res;
        int nk, nr;
        nk = (s != 0) ? 8 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'd2);
            end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) st[i] = d[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[st[4*((i/4 + i%4) % 4) + i%4]];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    st[4*c + i] = (r == nr) ? t[4*c + i] :
                        gmul(8'd2, t[4*c + i]) ^ gmul(8'd3, t[4*c + (i+1)%4]) ^ t[4*c + (i+2)%4] ^ t[4*c + (i+3)%4];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ov(input int s, output int n);
        n = 0;
        while (o_ov[s] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input int s, input logic [127:0] d, input logic [255:0] k,
                             input int stall, input logic [127:0] exp);
        int n;
        nblk++;
        chk($sformatf("in_ready_idle%0d", s), 256'(o_ir[s]), 256'(1));
        v_din[s] = d;
        v_key[s] = k;
        v_in[s]  = 1'b1;
        v_or[s]  = (stall == 0);
        @(negedge clk);
        v_in[s]  = 1'b0;
        v_din[s] = {$urandom, $urandom, $urandom, $urandom};
        v_key[s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        chk($sformatf("round_flags%0d", s), 256'({o_ir[s], o_busy[s], o_ov[s]}), 256'(3'b010));
        wait_ov(s, n);
        if (o_ov[s] === 1'b1) ndone++;
        chk($sformatf("latency%0d", s), 256'(n), 256'((s != 0) ? 14 : 10));
        chk($sformatf("dout%0d", s), 256'(o_dout[s]), 256'(exp));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", s), 256'({o_ov[s], o_ir[s], o_dout[s]}), 256'({2'b10, exp}));
        end
        v_or[s] = 1'b1;
        @(negedge clk);
        chk($sformatf("back_idle%0d", s), 256'({o_ir[s], o_ov[s], o_busy[s], o_dout[s]}), 256'({3'b100, exp}));
    endtask

    initial begin
        logic [7:0] inv;
        logic [127:0] d;
        logic [255:0] k;
        int n, cnt, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        rst_n = 1'b0;
        v_in = '0;
        v_or = '0;
        v_din = '0;
        v_key = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_state%0d", i), 256'({o_ir[i], o_ov[i], o_busy[i], o_dout[i]}), 256'(0));
        rst_n = 1'b1;
        #1;
        run_block(0, D, K128, 0, V128);
        run_block(1, D, K256, 0, V256);
        run_block(0, D, K128, 20, V128);
        run_block(1, D, K256, 3, V256);

        // in_valid held through ROUND with new data: only the first block counts until IDLE
        d = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        v_din[0] = D;
        v_key[0] = K128;
        v_in[0]  = 1'b1;
        v_or[0]  = 1'b1;
        @(negedge clk);
        v_din[0] = d;
        v_key[0] = k;
        wait_ov(0, n);
        chk("hold_latency", 256'(n), 256'(10));
        chk("hold_dout", 256'(o_dout[0]), 256'(V128));
        @(negedge clk);
        chk("hold_idle", 256'({o_ir[0], o_ov[0]}), 256'(2'b10));
        @(negedge clk);
        chk("hold_second_busy", 256'(o_busy[0]), 256'(1));
        v_in[0] = 1'b0;
        wait_ov(0, n);
        chk("second_latency", 256'(n), 256'(10));
        chk("second_dout", 256'(o_dout[0]), 256'(ref_enc(0, d, k)));
        @(negedge clk);

        // reset asserted during round 5
        v_din[0] = D;
        v_key[0] = K128;
        v_in[0]  = 1'b1;
        @(negedge clk);
        v_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 256'(o_busy[0]), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_clear", 256'({o_ir[0], o_ov[0], o_busy[0], o_dout[0]}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_ov[0] !== 1'b0) cnt++;
        end
        chk("no_ov_after_reset", 256'(cnt), 256'(0));
        chk("idle_after_reset", 256'({o_ir[0], o_busy[0]}), 256'(2'b10));
        run_block(0, D, K128, 0, V128);

        for (int i = 0; i < 100; i++) begin
            s = i % 2;
            d = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_block(s, d, k, $urandom_range(0, 3), ref_enc(s, d, k));
        end
        chk("completions", 256'(ndone), 256'(nblk));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
